// File: rtl/d_branch_pkg.sv
// Shared types and helpers for the D-stage branch resolver and its pattern history table.
package d_branch_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LEZ = 3'd2,
        CMP_GTZ = 3'd3,
        CMP_LTZ = 3'd4,
        CMP_GEZ = 3'd5,
        CMP_ODD = 3'd6,
        CMP_LTU = 3'd7
    } cmp_op_e;

    // Weakly-not-taken: one below the taken threshold (0 for a 1-bit counter).
    function automatic int unsigned ctr_reset_value(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/d_branch_resolve_unit_if.sv
// D-stage branch resolution bus: pipeline side is master, resolver is slave.
interface d_branch_resolve_unit_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned STAT_BITS = 32
);
    logic                 stall;
    logic                 flush;
    logic                 branch;
    logic [2:0]           cmp_op;
    logic                 link_en;
    logic [WIDTH-1:0]     rs_value;
    logic [WIDTH-1:0]     rt_value;
    logic [PC_WIDTH-1:0]  d_pc;
    logic                 d_pred_taken;
    logic [PC_WIDTH-1:0]  f_pc;
    logic                 f_pred_taken;
    logic                 pc_src;
    logic                 link_wr;
    logic                 mispredict;
    logic [STAT_BITS-1:0] branch_count;
    logic [STAT_BITS-1:0] mispredict_count;

    modport master (
        output stall, flush, branch, cmp_op, link_en, rs_value, rt_value,
               d_pc, d_pred_taken, f_pc,
        input  f_pred_taken, pc_src, link_wr, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  stall, flush, branch, cmp_op, link_en, rs_value, rt_value,
               d_pc, d_pred_taken, f_pc,
        output f_pred_taken, pc_src, link_wr, mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table of saturating counters: asynchronous read port, one
// saturating update port, all entries reset to weakly-not-taken.
module bp_pht
    import d_branch_pkg::*;
#(
    parameter int unsigned PHT_DEPTH = 16,
    parameter int unsigned CTR_BITS  = 2,
    localparam int unsigned IDX      = idx_width(PHT_DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [IDX-1:0] rd_idx_i,
    output logic           rd_taken_o,
    input  logic           upd_en_i,
    input  logic [IDX-1:0] upd_idx_i,
    input  logic           upd_taken_i
);
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(ctr_reset_value(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};

    logic [CTR_BITS-1:0] pht_q [PHT_DEPTH];
    logic [CTR_BITS-1:0] cur_ctr;
    logic [CTR_BITS-1:0] upd_ctr_d;

    // No bypass: a same-cycle update is visible on the read port only next cycle.
    assign rd_taken_o = pht_q[rd_idx_i][CTR_BITS-1];
    assign cur_ctr    = pht_q[upd_idx_i];

    always_comb begin
        upd_ctr_d = cur_ctr;
        if (upd_taken_i) begin
            if (cur_ctr != CtrMax) upd_ctr_d = cur_ctr + 1'b1;
        end else begin
            if (cur_ctr != '0) upd_ctr_d = cur_ctr - 1'b1;
        end
    end

    for (genvar g = 0; g < PHT_DEPTH; g++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pht_q[g] <= CtrInit;
            end else if (upd_en_i && (upd_idx_i == IDX'(g))) begin
                pht_q[g] <= upd_ctr_d;
            end
        end
    end

endmodule

// File: rtl/d_branch_resolve_unit.sv
// D-stage branch resolver: 8-way compare, taken/link/mispredict outputs, PHT
// training and wrap-around branch/mispredict statistics.
module d_branch_resolve_unit
    import d_branch_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned PHT_DEPTH = 16,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned STAT_BITS = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    d_branch_resolve_unit_if.slave  bus
);
    localparam int unsigned IDX = idx_width(PHT_DEPTH);

    logic cond;
    logic resolve;
    logic upd;
    logic rs_neg;
    logic rs_zero;
    logic f_pred_taken;
    logic [STAT_BITS-1:0] branch_count_q, branch_count_d;
    logic [STAT_BITS-1:0] mispredict_count_q, mispredict_count_d;

    assign rs_neg  = bus.rs_value[WIDTH-1];
    assign rs_zero = (bus.rs_value == '0);

    always_comb begin
        cond = 1'b0;
        unique case (cmp_op_e'(bus.cmp_op))
            CMP_EQ:  cond = (bus.rs_value == bus.rt_value);
            CMP_NE:  cond = (bus.rs_value != bus.rt_value);
            CMP_LEZ: cond = rs_neg | rs_zero;
            CMP_GTZ: cond = ~rs_neg & ~rs_zero;
            CMP_LTZ: cond = rs_neg;
            CMP_GEZ: cond = ~rs_neg;
            CMP_ODD: cond = ^bus.rs_value;
            CMP_LTU: cond = (bus.rs_value < bus.rt_value);
        endcase
    end

    assign resolve        = bus.branch & ~bus.flush;
    assign upd            = resolve & ~bus.stall;
    assign bus.pc_src     = resolve & cond;
    assign bus.link_wr    = resolve & cond & bus.link_en;
    // Left ungated by stall; the hazard unit decides when to act on it.
    assign bus.mispredict = resolve & (cond != bus.d_pred_taken);

    bp_pht #(
        .PHT_DEPTH (PHT_DEPTH),
        .CTR_BITS  (CTR_BITS)
    ) u_pht (
        .clk_i       (clk),
        .rst_ni      (reset),
        .rd_idx_i    (bus.f_pc[IDX+1:2]),
        .rd_taken_o  (f_pred_taken),
        .upd_en_i    (upd),
        .upd_idx_i   (bus.d_pc[IDX+1:2]),
        .upd_taken_i (cond)
    );

    assign bus.f_pred_taken = f_pred_taken;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd) begin
            branch_count_d = branch_count_q + 1'b1;
            if (bus.mispredict) mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

endmodule
